// File: rtl/dmem_pkg.sv
// Shared types, widths and helpers for the data-memory initiator and its line buffer.
package dmem_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 64;
    localparam int unsigned ADDR_WIDTH_DEF   = 64;
    localparam int unsigned LINE_WIDTH_DEF   = 256;
    localparam int unsigned TIMEOUT_DEF      = 255;
    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam int unsigned WORD_SEL_BITS    = 2;
    localparam int unsigned STRB_WIDTH       = 8;
    localparam int unsigned CNT_WIDTH        = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Byte index of the lowest set strobe bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_strb_idx(input logic [STRB_WIDTH-1:0] strb);
        lowest_strb_idx = 3'd0;
        for (int i = STRB_WIDTH - 1; i >= 0; i--) begin
            if (strb[i]) lowest_strb_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/dmem_initiator_if.sv
// CPU-side request/response and memory-side read/write signals of the initiator.
interface dmem_initiator_if
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int unsigned CACHE_LINE_WIDTH = LINE_WIDTH_DEF
);
    logic                        i_cpu_req_valid;
    logic                        o_cpu_req_ready;
    logic                        i_cpu_we;
    logic [ADDR_WIDTH-1:0]       i_cpu_addr;
    logic [DATA_WIDTH-1:0]       i_cpu_wdata;
    logic [STRB_WIDTH-1:0]       i_cpu_wstrb;
    logic                        o_cpu_resp_valid;
    logic [DATA_WIDTH-1:0]       o_cpu_rdata;
    logic                        o_cpu_err;
    logic                        o_mem_read_req;
    logic [ADDR_WIDTH-1:0]       o_mem_read_address;
    logic                        i_mem_read_done;
    logic [CACHE_LINE_WIDTH-1:0] i_cache_line;
    logic                        o_mem_write_valid;
    logic [DATA_WIDTH-1:0]       o_mem_write_data;
    logic [ADDR_WIDTH-1:0]       o_mem_write_address;
    logic [STRB_WIDTH-1:0]       o_write_strobe;
    logic                        i_mem_write_done;

    modport master (
        input  i_cpu_req_valid, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_wstrb,
        input  i_mem_read_done, i_cache_line, i_mem_write_done,
        output o_cpu_req_ready, o_cpu_resp_valid, o_cpu_rdata, o_cpu_err,
        output o_mem_read_req, o_mem_read_address,
        output o_mem_write_valid, o_mem_write_data, o_mem_write_address, o_write_strobe
    );

    modport slave (
        output i_cpu_req_valid, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_wstrb,
        output i_mem_read_done, i_cache_line, i_mem_write_done,
        input  o_cpu_req_ready, o_cpu_resp_valid, o_cpu_rdata, o_cpu_err,
        input  o_mem_read_req, o_mem_read_address,
        input  o_mem_write_valid, o_mem_write_data, o_mem_write_address, o_write_strobe
    );
endinterface

// File: rtl/dmem_line_buf.sv
// Single-line read buffer: line data, tag and valid bit, with line fill and byte-strobe merge.
module dmem_line_buf
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int unsigned CACHE_LINE_WIDTH = LINE_WIDTH_DEF,
    localparam int unsigned TAG_WIDTH       = ADDR_WIDTH - LINE_OFFSET_BITS
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_fill_en,
    input  logic [CACHE_LINE_WIDTH-1:0] i_fill_line,
    input  logic [TAG_WIDTH-1:0]        i_fill_tag,
    input  logic                        i_merge_en,
    input  logic [WORD_SEL_BITS-1:0]    i_merge_word,
    input  logic [DATA_WIDTH-1:0]       i_merge_data,
    input  logic [STRB_WIDTH-1:0]       i_merge_strb,
    input  logic                        i_invalidate,
    output logic [CACHE_LINE_WIDTH-1:0] o_line,
    output logic [TAG_WIDTH-1:0]        o_tag,
    output logic                        o_valid
);
    logic [CACHE_LINE_WIDTH-1:0] line_q, line_d;
    logic [TAG_WIDTH-1:0]        tag_q;
    logic                        valid_q;
    logic [5:0]                  shift_d;
    logic [DATA_WIDTH-1:0]       merge_data_d;

    // Store data arrives right-aligned; move it up to the first enabled byte lane.
    always_comb begin
        shift_d      = {lowest_strb_idx(i_merge_strb), 3'b000};
        merge_data_d = i_merge_data << shift_d;
        line_d       = line_q;
        for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            if (i_merge_strb[b]) begin
                line_d[DATA_WIDTH*int'(i_merge_word) + 8*b +: 8] = merge_data_d[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
        end else if (i_fill_en) begin
            line_q  <= i_fill_line;
            tag_q   <= i_fill_tag;
            valid_q <= 1'b1;
        end else if (i_merge_en) begin
            line_q <= line_d;
        end else if (i_invalidate) begin
            valid_q <= 1'b0;
        end
    end

    assign o_line  = line_q;
    assign o_tag   = tag_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/dmem_initiator.sv
// CPU load/store initiator with a one-line read buffer, memory read/write handshakes and wait timeout.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int unsigned CACHE_LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int unsigned TIMEOUT          = TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dmem_initiator_if.master bus
);
    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - LINE_OFFSET_BITS;

    state_e                      state_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [WORD_SEL_BITS-1:0]    req_word_q;
    logic [TAG_WIDTH-1:0]        req_tag_q;
    logic                        rd_req_q, wr_valid_q, resp_valid_q, err_q;
    logic [ADDR_WIDTH-1:0]       rd_addr_q, wr_addr_q;
    logic [DATA_WIDTH-1:0]       wr_data_q, rdata_q;
    logic [STRB_WIDTH-1:0]       wr_strb_q;

    logic                        accept, tag_hit, timeout_hit, rd_done, wr_done;
    logic [TAG_WIDTH-1:0]        cpu_tag, buf_tag;
    logic [WORD_SEL_BITS-1:0]    cpu_word;
    logic [CACHE_LINE_WIDTH-1:0] buf_line;
    logic                        buf_valid;

    function automatic logic [DATA_WIDTH-1:0] line_word(input logic [CACHE_LINE_WIDTH-1:0] line,
                                                        input logic [WORD_SEL_BITS-1:0]    sel);
        return line[DATA_WIDTH*int'(sel) +: DATA_WIDTH];
    endfunction

    assign bus.o_cpu_req_ready = (state_q == IDLE) && !i_rst;
    assign accept      = bus.i_cpu_req_valid && bus.o_cpu_req_ready;
    assign cpu_tag     = bus.i_cpu_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS];
    assign cpu_word    = bus.i_cpu_addr[LINE_OFFSET_BITS-1 -: WORD_SEL_BITS];
    assign tag_hit     = buf_valid && (buf_tag == cpu_tag);
    assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT - 1));
    assign rd_done     = (state_q == RD_WAIT) && bus.i_mem_read_done;
    assign wr_done     = (state_q == WR_WAIT) && bus.i_mem_write_done;

    dmem_line_buf #(
        .DATA_WIDTH       (DATA_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .CACHE_LINE_WIDTH (CACHE_LINE_WIDTH)
    ) u_line_buf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fill_en    (rd_done),
        .i_fill_line  (bus.i_cache_line),
        .i_fill_tag   (req_tag_q),
        .i_merge_en   (accept && bus.i_cpu_we && (bus.i_cpu_wstrb != '0) && tag_hit),
        .i_merge_word (cpu_word),
        .i_merge_data (bus.i_cpu_wdata),
        .i_merge_strb (bus.i_cpu_wstrb),
        .i_invalidate ((state_q == WR_WAIT) && !bus.i_mem_write_done && timeout_hit),
        .o_line       (buf_line),
        .o_tag        (buf_tag),
        .o_valid      (buf_valid)
    );

    // Main FSM; response strobe and data are single-cycle and default low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_word_q   <= '0;
            req_tag_q    <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_word_q <= cpu_word;
                        req_tag_q  <= cpu_tag;
                        cnt_q      <= '0;
                        if (!bus.i_cpu_we && tag_hit) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= line_word(buf_line, cpu_word);
                        end else if (!bus.i_cpu_we) begin
                            state_q   <= RD_WAIT;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= {cpu_tag, LINE_OFFSET_BITS'(0)};
                        end else if (bus.i_cpu_wstrb != '0) begin
                            state_q    <= WR_WAIT;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= {bus.i_cpu_addr[ADDR_WIDTH-1:3], 3'b000};
                            wr_data_q  <= bus.i_cpu_wdata;
                            wr_strb_q  <= bus.i_cpu_wstrb;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_done || timeout_hit) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= !rd_done;
                        rdata_q      <= rd_done ? line_word(bus.i_cache_line, req_word_q) : '0;
                        rd_req_q     <= 1'b0;
                        rd_addr_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                WR_WAIT: begin
                    if (wr_done || timeout_hit) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= !wr_done;
                        wr_valid_q   <= 1'b0;
                        wr_addr_q    <= '0;
                        wr_data_q    <= '0;
                        wr_strb_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_cpu_resp_valid    = resp_valid_q;
    assign bus.o_cpu_rdata         = rdata_q;
    assign bus.o_cpu_err           = err_q;
    assign bus.o_mem_read_req      = rd_req_q;
    assign bus.o_mem_read_address  = rd_addr_q;
    assign bus.o_mem_write_valid   = wr_valid_q;
    assign bus.o_mem_write_data    = wr_data_q;
    assign bus.o_mem_write_address = wr_addr_q;
    assign bus.o_write_strobe      = wr_strb_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator: directed loads/stores, timeouts and mid-transaction reset.
module tb_dmem_initiator;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    localparam logic [255:0] LINE1 = {64'h3333, 64'h2222, 64'hAAAA, 64'h5555_6666_7777_8888};
    localparam logic [255:0] LINE2 = {64'h0D0D, 64'h0C0C, 64'hC0FFEE, 64'h0A0A};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_initiator_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .CACHE_LINE_WIDTH(256)) bus ();

    dmem_initiator #(
        .DATA_WIDTH(64), .ADDR_WIDTH(64), .CACHE_LINE_WIDTH(256), .TIMEOUT(255)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response is popped against the scoreboard, err must stay low otherwise.
    always @(negedge clk) begin
        if (bus.o_cpu_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(bus.o_cpu_rdata), 64'hDEAD_0000_0000_DEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", bus.o_cpu_rdata, e.rdata);
                check("resp_err", 64'(bus.o_cpu_err), 64'(e.err));
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            check("err_without_resp", 64'(bus.o_cpu_err), 64'd0);
        end
    end

    task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] strb, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        bus.i_cpu_req_valid = 1'b1;
        bus.i_cpu_we        = we;
        bus.i_cpu_addr      = addr;
        bus.i_cpu_wdata     = wdata;
        bus.i_cpu_wstrb     = strb;
        while (!bus.o_cpu_req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.i_cpu_req_valid = 1'b0;
    endtask

    task automatic load_hit(input logic [63:0] addr, input logic [63:0] exp_rdata);
        int acc;
        issue(1'b0, addr, 64'd0, 8'd0, acc);
        exp_q.push_back('{exp_rdata, 1'b0, acc});
        @(negedge clk);
        check("hit_no_read_req", 64'(bus.o_mem_read_req), 64'd0);
    endtask

    task automatic serve_read(input logic [63:0] exp_addr, input logic [255:0] line,
                              input logic [63:0] exp_rdata, input int waits);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("read_req_held", 64'(bus.o_mem_read_req), 64'd1);
            check("read_address", bus.o_mem_read_address, exp_addr);
        end
        bus.i_mem_read_done = 1'b1;
        bus.i_cache_line    = line;
        exp_q.push_back('{exp_rdata, 1'b0, cyc + 1});
        @(posedge clk);
        #1;
        bus.i_mem_read_done = 1'b0;
        @(negedge clk);
        check("read_req_drop", 64'(bus.o_mem_read_req), 64'd0);
    endtask

    task automatic serve_write(input logic [63:0] exp_addr, input logic [63:0] exp_data,
                               input logic [7:0] exp_strb, input int waits);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("write_valid_held", 64'(bus.o_mem_write_valid), 64'd1);
            check("write_address", bus.o_mem_write_address, exp_addr);
            check("write_data", bus.o_mem_write_data, exp_data);
            check("write_strobe", 64'(bus.o_write_strobe), 64'(exp_strb));
        end
        bus.i_mem_write_done = 1'b1;
        exp_q.push_back('{64'd0, 1'b0, cyc + 1});
        @(posedge clk);
        #1;
        bus.i_mem_write_done = 1'b0;
        @(negedge clk);
        check("write_valid_drop", 64'(bus.o_mem_write_valid), 64'd0);
    endtask

    task automatic wait_resp(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.o_cpu_resp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check(name, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int acc;
        int cnt;
        bus.i_cpu_req_valid  = 1'b0;
        bus.i_cpu_we         = 1'b0;
        bus.i_cpu_addr       = '0;
        bus.i_cpu_wdata      = '0;
        bus.i_cpu_wstrb      = '0;
        bus.i_mem_read_done  = 1'b0;
        bus.i_mem_write_done = 1'b0;
        bus.i_cache_line     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 64'(bus.o_cpu_req_ready), 64'd0);
        check("read_req_reset", 64'(bus.o_mem_read_req), 64'd0);
        check("write_valid_reset", 64'(bus.o_mem_write_valid), 64'd0);
        check("resp_valid_reset", 64'(bus.o_cpu_resp_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(bus.o_cpu_req_ready), 64'd1);

        // Load miss, line returned after three wait cycles.
        issue(1'b0, 64'h1008, 64'd0, 8'd0, acc);
        serve_read(64'h1000, LINE1, 64'hAAAA, 3);

        // Same line, other word: served from the buffer.
        load_hit(64'h1010, 64'h2222);

        // Partial store merges into word0 bytes [3:2] and is forwarded unshifted.
        issue(1'b1, 64'h1002, 64'hBEEF, 8'h0C, acc);
        serve_write(64'h1000, 64'hBEEF, 8'h0C, 2);
        load_hit(64'h1000, 64'h5555_6666_BEEF_8888);

        // Zero-strobe store: immediate response, no memory write.
        issue(1'b1, 64'h1008, 64'hFFFF, 8'h00, acc);
        exp_q.push_back('{64'd0, 1'b0, acc});
        @(negedge clk);
        check("zero_strb_no_write", 64'(bus.o_mem_write_valid), 64'd0);
        @(negedge clk);
        bus.i_mem_read_done  = 1'b1;
        bus.i_mem_write_done = 1'b1;
        bus.i_cache_line     = '1;
        @(posedge clk);
        #1;
        bus.i_mem_read_done  = 1'b0;
        bus.i_mem_write_done = 1'b0;
        @(negedge clk);
        check("stray_done_ready", 64'(bus.o_cpu_req_ready), 64'd1);
        load_hit(64'h1008, 64'hAAAA);

        // Load miss with no done: 255 wait cycles then error; buffer untouched.
        issue(1'b0, 64'h2000, 64'd0, 8'd0, acc);
        exp_q.push_back('{64'd0, 1'b1, acc + 255});
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.o_cpu_resp_valid) break;
            if (bus.o_mem_read_req) cnt++;
        end
        check("read_timeout_wait_cycles", 64'(cnt), 64'd255);
        load_hit(64'h1008, 64'hAAAA);

        // Store whose done lands on the timeout cycle: done wins.
        issue(1'b1, 64'h1008, 64'h1234, 8'hFF, acc);
        exp_q.push_back('{64'd0, 1'b0, acc + 255});
        for (int i = 0; i < 400 && cyc < acc + 254; i++) @(negedge clk);
        bus.i_mem_write_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mem_write_done = 1'b0;
        @(negedge clk);
        check("done_at_timeout_drop", 64'(bus.o_mem_write_valid), 64'd0);
        load_hit(64'h1008, 64'h1234);

        // Store timeout invalidates the buffer, so the next load misses.
        issue(1'b1, 64'h1008, 64'h77, 8'h01, acc);
        exp_q.push_back('{64'd0, 1'b1, acc + 255});
        wait_resp("store_timeout_wait", 400);
        @(negedge clk);
        check("store_timeout_drop", 64'(bus.o_mem_write_valid), 64'd0);
        issue(1'b0, 64'h1008, 64'd0, 8'd0, acc);
        serve_read(64'h1000, LINE1, 64'hAAAA, 1);

        // Reset in the middle of a read: request dropped, no response, buffer invalid.
        issue(1'b0, 64'h3000, 64'd0, 8'd0, acc);
        @(negedge clk);
        check("pre_reset_read_req", 64'(bus.o_mem_read_req), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_read_req", 64'(bus.o_mem_read_req), 64'd0);
        check("reset_read_address", bus.o_mem_read_address, 64'd0);
        check("reset_ready", 64'(bus.o_cpu_req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 64'h1008, 64'd0, 8'd0, acc);
        serve_read(64'h1000, LINE2, 64'hC0FFEE, 2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_initiator.md
DMEM_INITIATOR -- requirements
Module: dmem_initiator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, CPU word and memory write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 SHALL have parameter CACHE_LINE_WIDTH, default 256, memory read line width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max wait cycles per memory transaction.
REQ-005 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have CPU ports: i_cpu_req_valid in 1; o_cpu_req_ready out 1; i_cpu_we in 1 (1=store); i_cpu_addr in ADDR_WIDTH; i_cpu_wdata in DATA_WIDTH, right-aligned; i_cpu_wstrb in 8, lane-aligned.
REQ-007 SHALL have CPU response ports: o_cpu_resp_valid out 1 pulse; o_cpu_rdata out DATA_WIDTH; o_cpu_err out 1 timeout flag.
REQ-008 SHALL have memory read ports: o_mem_read_req out 1; o_mem_read_address out ADDR_WIDTH; i_mem_read_done in 1; i_cache_line in CACHE_LINE_WIDTH.
REQ-009 SHALL have memory write ports: o_mem_write_valid out 1; o_mem_write_data out DATA_WIDTH; o_mem_write_address out ADDR_WIDTH; o_write_strobe out 8; i_mem_write_done in 1.

Function
REQ-010 SHALL implement FSM IDLE, RD_WAIT, WR_WAIT, RESP; o_cpu_req_ready = (state==IDLE) and not i_rst.
REQ-011 SHALL accept a request on an edge where valid and ready are both high, and register addr, we, wdata, wstrb.
REQ-012 SHALL hold a one-line buffer: 256-bit data, tag = addr[ADDR_WIDTH-1:5], valid bit.
REQ-013 Load hit (valid, tag match): IDLE->RESP; o_cpu_resp_valid at accept+1; rdata = buffer word addr[4:3].
REQ-014 Load miss: IDLE->RD_WAIT; o_mem_read_req high from accept+1 until done; o_mem_read_address = addr with bits [4:0] zeroed, held stable.
REQ-015 In RD_WAIT, on sampled i_mem_read_done: capture i_cache_line into buffer, set tag and valid, go RESP; resp at done+1 with word addr[4:3].
REQ-016 Store with nonzero wstrb: IDLE->WR_WAIT; o_mem_write_valid high until i_mem_write_done; address = addr with bits [2:0] zeroed; data = wdata unchanged; strobe = wstrb; all held stable.
REQ-017 Store to buffered line SHALL merge bytes into the buffer word addr[4:3] at accept. The merge data is wdata shifted left by 8 x the index of the lowest set wstrb bit.
REQ-018 Store with wstrb==0: IDLE->RESP; no memory write, buffer unchanged, resp at accept+1.
REQ-019 On write done: WR_WAIT->RESP; resp at done+1 with rdata=0.
REQ-020 RESP SHALL last exactly one cycle, then go to IDLE; responses have no backpressure.
REQ-021 An 8-bit wait counter SHALL clear on entry to RD_WAIT/WR_WAIT and increment each wait cycle. When it reaches TIMEOUT without done, the FSM SHALL drop the request and go RESP with o_cpu_err=1 and rdata=0.
REQ-022 Timeout on a load SHALL leave the buffer unchanged; timeout on a store SHALL clear buffer valid.
REQ-023 If done coincides with timeout, done SHALL win and err=0.
REQ-024 i_mem_read_done or i_mem_write_done outside its wait state SHALL be ignored.
REQ-025 o_cpu_err SHALL be valid only with o_cpu_resp_valid, else 0.

Reset
REQ-026 While i_rst is high at an edge: state=IDLE; buffer valid=0; counter=0; all outputs 0 the following cycle.
REQ-027 Reset mid-transaction SHALL abort it; no response is issued and requests deassert at the next edge.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enum, LINE_OFFSET_BITS=5, WORD_SEL_BITS=2 and the default widths.
REQ-029 Buffer storage and strobe merge SHALL be sub-module dmem_line_buf (line, tag, valid, merge port); the FSM and counter stay in dmem_initiator.

Verification
REQ-030 Load 0x1008, mem done after 3 cycles with line word1=0xAAAA -> read_address 0x1000; resp rdata 0xAAAA, err 0.
REQ-031 Then load 0x1010 -> no o_mem_read_req; resp at accept+1 with word2 of the line.
REQ-032 Store addr 0x1002, wdata 0xBEEF, wstrb 0x0C -> write_address 0x1000, data 0xBEEF, strobe 0x0C; buffer word0 bytes[3:2]=0xBEEF; reload hits.
REQ-033 Load miss, done never asserted -> resp at 255 wait cycles with err=1 and rdata 0; the next request is accepted.
REQ-034 i_rst pulsed during RD_WAIT -> read_req 0 next cycle; no resp; buffer invalid; next load 0x1008 misses.
REQ-035 Store with wstrb=0 -> no write_valid; resp at accept+1; done pulse in IDLE -> ignored.
